// File: rtl/freq_div_multi.sv
// freq_div_multi: bank of independent programmable clock dividers.
// Ports: speed_clock/reset_n, per-channel enable/mode/div_load/div_value,
//        per-channel low_clock/tick/div_err (all registered).
module freq_div_multi #(
    parameter int WIDTH       = 27,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic                      speed_clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] div_value,
    input  logic [CHANNELS-1:0]       div_load,
    output logic [CHANNELS-1:0]       low_clock,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       div_err
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cont_q, cont_d;
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] pend_q, pend_d;
        logic             pv_q, pv_d;
        logic             run_q;
        logic             lc_q, lc_d;
        logic             tk_q, tk_d;
        logic             er_q, er_d;
        logic [WIDTH-1:0] val;
        logic             ld_ok;
        logic             counting;
        logic             wrap;

        // run_q marks cycles that are part of a counting period; the
        // first cycle after enable rises always starts at cont=0.
        always_comb begin
            val      = div_value[i*WIDTH +: WIDTH];
            ld_ok    = div_load[i] && (val >= TWO);
            counting = enable[i] && run_q;
            wrap     = counting && (cont_q == div_q - ONE);
            cont_d   = '0;
            div_d    = div_q;
            pend_d   = pend_q;
            pv_d     = pv_q;
            if (!counting || wrap) begin
                // Period boundary (or idle): a fresh load wins over
                // an older pending value.
                if (ld_ok) begin
                    div_d = val;
                end else if (pv_q) begin
                    div_d = pend_q;
                end
                pv_d = 1'b0;
            end else begin
                cont_d = cont_q + ONE;
                if (ld_ok) begin
                    pend_d = val;
                    pv_d   = 1'b1;
                end
            end
            // Outputs are precomputed from next state so the registered
            // value matches the cycle's own cont/D.
            tk_d = enable[i] && (cont_d == div_d - ONE);
            if (mode[i]) begin
                lc_d = tk_d;
            end else begin
                lc_d = enable[i] && (cont_d >= div_d - (div_d >> 1));
            end
            er_d = enable[i] && div_load[i] && (val < TWO);
        end

        always_ff @(posedge speed_clock or negedge reset_n) begin
            if (!reset_n) begin
                cont_q <= '0;
                div_q  <= DEF;
                pend_q <= '0;
                pv_q   <= 1'b0;
                run_q  <= 1'b0;
                lc_q   <= 1'b0;
                tk_q   <= 1'b0;
                er_q   <= 1'b0;
            end else begin
                cont_q <= cont_d;
                div_q  <= div_d;
                pend_q <= pend_d;
                pv_q   <= pv_d;
                run_q  <= enable[i];
                lc_q   <= lc_d;
                tk_q   <= tk_d;
                er_q   <= er_d;
            end
        end

        assign low_clock[i] = lc_q;
        assign tick[i]      = tk_q;
        assign div_err[i]   = er_q;
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// tb_freq_div_multi: directed bench for freq_div_multi
// (WIDTH=8, CHANNELS=2, DEFAULT_DIV=10).
module tb_freq_div_multi;

    logic        speed_clock;
    logic        reset_n;
    logic [1:0]  enable;
    logic [1:0]  mode;
    logic [15:0] div_value;
    logic [1:0]  div_load;
    logic [1:0]  low_clock;
    logic [1:0]  tick;
    logic [1:0]  div_err;

    int checks = 0;
    int errors = 0;

    freq_div_multi #(
        .WIDTH(8),
        .CHANNELS(2),
        .DEFAULT_DIV(10)
    ) dut (
        .speed_clock(speed_clock),
        .reset_n(reset_n),
        .enable(enable),
        .mode(mode),
        .div_value(div_value),
        .div_load(div_load),
        .low_clock(low_clock),
        .tick(tick),
        .div_err(div_err)
    );

    initial speed_clock = 1'b0;
    always #5 speed_clock = ~speed_clock;

    typedef struct {
        logic [1:0] en;
        logic [1:0] md;
        logic [1:0] ld;
        logic [7:0] v0;
        logic [7:0] v1;
        logic [1:0] lc;
        logic [1:0] tk;
        logic [1:0] er;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [1:0] got,
                       input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge speed_clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = '0;
        mode      = '0;
        div_load  = '0;
        div_value = '0;
        @(posedge speed_clock);
        #1;
        chk("reset low_clock", low_clock, 2'b00);
        chk("reset tick", tick, 2'b00);
        chk("reset div_err", div_err, 2'b00);
        reset_n = 1'b1;
    endtask

    initial begin
        // Step 0: ch1 gets D=3 while idle. Then both run:
        // ch0 mode 0 D=10 (load 7 mid-period, then loads 1 and 0
        // rejected), ch1 mode 1 D=3.
        tbl[0]  = '{2'b00, 2'b00, 2'b10, 8'd0, 8'd3, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b10, 2'b10, 2'b00};
        tbl[4]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[5]  = '{2'b11, 2'b10, 2'b01, 8'd7, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b11, 2'b10, 2'b00};
        tbl[7]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00};
        tbl[8]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00};
        tbl[9]  = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b11, 2'b10, 2'b00};
        tbl[10] = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00};
        tbl[11] = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[12] = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b10, 2'b10, 2'b00};
        tbl[13] = '{2'b11, 2'b10, 2'b01, 8'd1, 8'd0, 2'b00, 2'b00, 2'b01};
        tbl[14] = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[15] = '{2'b11, 2'b10, 2'b01, 8'd0, 8'd0, 2'b11, 2'b10, 2'b01};
        tbl[16] = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00};
        tbl[17] = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00};
        tbl[18] = '{2'b11, 2'b10, 2'b00, 8'd0, 8'd0, 2'b10, 2'b10, 2'b00};

        do_reset();
        for (int k = 0; k < 19; k++) begin
            enable    = tbl[k].en;
            mode      = tbl[k].md;
            div_load  = tbl[k].ld;
            div_value = {tbl[k].v1, tbl[k].v0};
            step();
            chk($sformatf("tbl[%0d] low_clock", k), low_clock, tbl[k].lc);
            chk($sformatf("tbl[%0d] tick", k), tick, tbl[k].tk);
            chk($sformatf("tbl[%0d] div_err", k), div_err, tbl[k].er);
        end

        // Disable at cont=6, load 4 while idle, re-enable; then load 5
        // exactly at the last cycle, then switch to pulse mode.
        do_reset();
        enable = 2'b01;
        for (int n = 0; n < 7; n++) step();
        chk("pre-disable lc cont6", low_clock, 2'b01);
        enable    = 2'b00;
        div_load  = 2'b01;
        div_value = 16'd4;
        step();
        div_load  = 2'b00;
        chk("disabled lc", low_clock, 2'b00);
        chk("disabled tick", tick, 2'b00);
        step();
        chk("disabled lc 2", low_clock, 2'b00);
        enable = 2'b01;
        for (int n = 0; n < 18; n++) begin
            int c;
            int d;
            logic etk;
            logic elc;
            div_load  = (n == 8) ? 2'b01 : 2'b00;
            div_value = (n == 8) ? 16'd5 : 16'd0;
            mode      = (n >= 13) ? 2'b01 : 2'b00;
            d   = (n < 8) ? 4 : 5;
            c   = (n < 8) ? (n % 4) : ((n - 8) % 5);
            etk = (c == d - 1);
            elc = (n >= 13) ? etk : (c >= d - d / 2);
            step();
            chk($sformatf("reen n%0d tick", n), tick, {1'b0, etk});
            chk($sformatf("reen n%0d lc", n), low_clock, {1'b0, elc});
        end

        // Reset at cont=8 while a pending divisor of 5 is waiting.
        do_reset();
        mode   = 2'b00;
        enable = 2'b01;
        for (int n = 0; n < 9; n++) begin
            div_load  = (n == 3) ? 2'b01 : 2'b00;
            div_value = (n == 3) ? 16'd5 : 16'd0;
            step();
        end
        div_load = 2'b00;
        chk("pre-reset lc cont8", low_clock, 2'b01);
        reset_n = 1'b0;
        #1;
        chk("async reset lc", low_clock, 2'b00);
        chk("async reset tick", tick, 2'b00);
        #2;
        reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            chk($sformatf("post-rst n%0d tick", n), tick,
                {1'b0, (n % 10) == 9});
            chk($sformatf("post-rst n%0d lc", n), low_clock,
                {1'b0, (n % 10) >= 5});
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_div_multi.md
FREQ_DIV_MULTI -- requirements
Module: freq_div_multi

Interface
REQ-001 Parameter WIDTH, default 27: bit width of each channel's divisor and counter.
REQ-002 Parameter CHANNELS, default 2: number of independent divider channels.
REQ-003 Parameter DEFAULT_DIV, default 50_000_000: divisor loaded at reset (1 Hz from 50 MHz); SHALL satisfy 2 <= DEFAULT_DIV < 2^WIDTH.
REQ-004 speed_clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  CHANNELS  per-channel run enable; 1 = count.
REQ-007 mode  in  CHANNELS  per-channel output mode; 0 = square wave, 1 = single-cycle pulse.
REQ-008 div_value  in  CHANNELS*WIDTH  requested divisor; channel i uses bits [i*WIDTH +: WIDTH].
REQ-009 div_load  in  CHANNELS  one-cycle strobe that requests capture of the channel's div_value slice.
REQ-010 low_clock  out  CHANNELS  divided clock or pulse, per mode.
REQ-011 tick  out  CHANNELS  one-cycle strobe in the last cycle of each period.
REQ-012 div_err  out  CHANNELS  one-cycle strobe flagging a rejected divisor load.

Function
REQ-013 Each channel SHALL hold a counter cont (WIDTH bits), an active divisor D, and a pending divisor with a valid flag.
REQ-014 When enabled, cont SHALL count 0,1,...,D-1 and then wrap to 0, giving a period of exactly D cycles.
REQ-015 All outputs SHALL be registered and SHALL be glitch-free; each output's value in a cycle SHALL be a function of that same cycle's cont, D and mode.
REQ-016 tick[i] SHALL be 1 exactly in cycles where enable[i]=1 and cont==D-1.
REQ-017 Mode 0: low_clock[i] SHALL be 1 exactly in cycles where cont >= D-floor(D/2).
  - Result: high for floor(D/2) cycles, low for ceil(D/2) cycles.
  - Odd D: low phase is one cycle longer.
REQ-018 Mode 1: low_clock[i] SHALL equal tick[i].
REQ-019 A mode change SHALL take effect in the next cycle; cont SHALL NOT be disturbed.
REQ-020 A div_load with div_value >= 2 SHALL write the value into pending and set the valid flag; a later load before the flag is used SHALL overwrite pending.
REQ-021 A div_load with div_value < 2 SHALL be rejected: pending unchanged, div_err[i]=1 in the following cycle only.
REQ-022 Pending divisor SHALL become D only at a wrap (cont==D-1 -> 0), then valid clears; the current period SHALL never be truncated or stretched.
REQ-023 A load in the same cycle as cont==D-1 SHALL be applied at that wrap.
REQ-024 While enable[i]=0:
  - cont held at 0; low_clock, tick and div_err SHALL be 0.
  - A valid pending divisor SHALL be applied to D immediately.
  - A valid load SHALL be written directly to D.
REQ-025 When enable rises, counting SHALL start from cont=0 in the next cycle.
REQ-026 Channels SHALL be fully independent; no cross-channel coupling.

Reset
REQ-027 On reset_n=0, for all channels, asynchronously:
  - cont=0, D=DEFAULT_DIV, pending valid=0.
  - low_clock=0, tick=0, div_err=0.
REQ-028 Reset asserted mid-period SHALL abort the period and discard any pending divisor.
REQ-029 After reset_n deasserts, counting SHALL begin on the first rising edge with enable=1.

Verification (WIDTH=8, CHANNELS=2, DEFAULT_DIV=10)
REQ-030 Ch0 enabled, mode 0, no loads -> tick every 10 cycles; low_clock 0 for 5 cycles, then 1 for 5 cycles (cont 5..9).
REQ-031 Ch0 div_load=1 with value 7 mid-period -> current 10-cycle period completes; next periods are 7 cycles; low_clock 4 low / 3 high.
REQ-032 Load value 1, then value 0 -> div_err pulses once per load; period remains 10.
REQ-033 Ch1 mode 1, D=3; ch0 mode 0, D=10 -> ch1 low_clock is a 1-cycle pulse every 3 cycles; ch0 unaffected.
REQ-034 Disable ch0 at cont=6, load value 4, re-enable -> outputs 0 while disabled; first period after re-enable is 4 cycles starting at cont=0.
REQ-035 reset_n pulsed low at cont=8 with a pending divisor of 5 -> all outputs 0 immediately; after release, period is 10 and the pending 5 is lost.
